// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DIVZERO_EN adds a div_zero flag and a short-cut for divisor == 0.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
`ifdef SEQ_DIVIDER_DIVZERO_EN
  output logic          done,
  output logic          div_zero
`else
  output logic          done
`endif
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            start_q;
  logic [DW-1:0]   q_reg;
  logic [VW-1:0]   d_reg;
  // The partial remainder always fits VW bits between steps; only the trial
  // value t needs the extra bit.
  logic [VW-1:0]   r_reg;
  logic [CW-1:0]   count;
  logic            accept;
  logic            dz_skip;

  logic [VW:0]     t;
  logic [VW:0]     diff;
  logic            ge;
  logic [VW-1:0]   r_step;

  assign accept = start & ~start_q & (state == IDLE);

`ifdef SEQ_DIVIDER_DIVZERO_EN
  logic dz_pend;
  assign dz_skip = dz_pend;
`else
  assign dz_skip = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign t      = {r_reg, q_reg[DW-1]};
  assign ge     = (t >= {1'b0, d_reg});
  assign diff   = t - {1'b0, d_reg};
  assign r_step = ge ? diff[VW-1:0] : t[VW-1:0];

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (dz_skip || count == CW'(DW-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
      dz_pend   <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= '0;
            busy  <= 1'b1;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            div_zero <= 1'b0;
            // Preload the final divide-by-zero results so DONE can publish them unchanged.
            if (divisor == '0) begin
              q_reg   <= '1;
              r_reg   <= dividend[VW-1:0];
              dz_pend <= 1'b1;
            end else begin
              dz_pend <= 1'b0;
            end
`endif
          end
        end
        RUN: begin
          if (!dz_skip) begin
            q_reg <= {q_reg[DW-2:0], ge};
            r_reg <= r_step;
            count <= count + 1'b1;
          end
        end
        DONE: begin
          quotient  <= q_reg;
          remainder <= r_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
          div_zero  <= dz_pend;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (default build and SEQ_DIVIDER_DIVZERO_EN build).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
`ifdef SEQ_DIVIDER_DIVZERO_EN
  logic        div_zero;
`endif

  int n_total = 0;
  int n_pass  = 0;

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
`ifdef SEQ_DIVIDER_DIVZERO_EN
    .done      (done),
    .div_zero  (div_zero)
`else
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE, measure cycles from the accept edge to done.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] exp_q, input logic [7:0] exp_r, input int exp_lat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'hBE;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n_done;
    int busy_drops;
    int wait_cyc;
    logic [15:0] cap_q;
    logic [7:0]  cap_r;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 16'h0000);
    check("rst_r", remainder, 8'h00);
    rst = 1'b0;
    tick();

    // Basic operation
    run_op("basic", 16'h2613, 8'h13, 16'h0201, 8'h00, 17);
`ifdef SEQ_DIVIDER_DIVZERO_EN
    check("basic_dz", div_zero, 1'b0);
`endif

    // Start held high for 60 cycles: exactly one operation
    dividend = 16'h31B7; divisor = 8'h35; start = 1'b1;
    n_done = 0; cap_q = '0; cap_r = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        n_done++;
        cap_q = quotient;
        cap_r = remainder;
      end
    end
    start = 1'b0;
    check("held_ndone", n_done, 1);
    check("held_q", cap_q, 16'h00F0);
    check("held_r", cap_r, 8'h07);
    check("held_idle", busy, 1'b0);
    tick();

    // Boundaries
    run_op("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 17);
    run_op("small", 16'h0005, 8'h07, 16'h0000, 8'h05, 17);
    run_op("ffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 17);

    // Second start edge during RUN is ignored
    dividend = 16'h2613; divisor = 8'h13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    dividend = 16'hFFFF; divisor = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_during_run", busy, 1'b1);
    busy_drops = 0; wait_cyc = 0;
    while (!done && wait_cyc < 40) begin
      if (!busy) busy_drops++;
      tick();
      wait_cyc++;
    end
    check("ign_done_seen", done, 1'b1);
    check("ign_busy_drops", busy_drops, 0);
    check("ign_q", quotient, 16'h0201);
    check("ign_r", remainder, 8'h00);
    check("ign_busy_after", busy, 1'b0);
    n_done = 0;
    repeat (25) begin
      tick();
      if (done) n_done++;
    end
    check("ign_no_second", n_done, 0);

    // Reset in the middle of RUN
    dividend = 16'h31B7; divisor = 8'h35; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, 16'h0000);
    check("midrst_r", remainder, 8'h00);
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_op("after_rst", 16'h31B7, 8'h35, 16'h00F0, 8'h07, 17);

    // Divide by zero
`ifdef SEQ_DIVIDER_DIVZERO_EN
    run_op("div0", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 2);
    check("div0_flag", div_zero, 1'b1);
    run_op("after_div0", 16'h0005, 8'h07, 16'h0000, 8'h05, 17);
    check("div0_flag_clr", div_zero, 1'b0);
`else
    run_op("div0", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 17);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
